// File: rtl/gray_codec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_codec_pkg
// Description : Shared definitions for the Gray-code conversion pipeline.
//               This package holds the following items:
//                 - the mode encodings;
//                 - the legal WIDTH range;
//                 - word-level reference functions.
//               The reference functions work on WIDTH_MAX-bit words. A
//               narrower code is zero-extended before it is passed in. Its
//               result is then the low WIDTH bits, because leading zeros
//               do not change either conversion.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_codec_pkg;

    localparam logic MODE_B2G  = 1'b0;   // binary in, Gray out
    localparam logic MODE_G2B  = 1'b1;   // Gray in, binary out

    localparam int   WIDTH_MIN = 2;
    localparam int   WIDTH_MAX = 32;

    typedef logic [WIDTH_MAX-1:0] word_t;

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b[WIDTH_MAX-1] = g[WIDTH_MAX-1];
        for (int i = WIDTH_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_codec_core.sv
`default_nettype none
// ============================================================================
// Module      : gray_codec_core
// Description : A purely combinational converter with a configurable width.
//               The i_mode input selects the conversion:
//                 - MODE_B2G : o_data = i_data ^ (i_data >> 1)
//                 - MODE_G2B : o_data[i] = XOR of i_data[WIDTH-1:i]
// Ports       : i_mode  - conversion select
//               i_data  - word to convert
//               o_data  - converted word
// Revision    : 1.0 - initial release
// ============================================================================
module gray_codec_core
    import gray_codec_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_gray;
    logic [WIDTH-1:0] w_bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == WIDTH - 1) begin : g_msb
            assign w_gray[i] = i_data[i];
        end else begin : g_low
            assign w_gray[i] = i_data[i] ^ i_data[i+1];
        end
        // Each bit is an independent reduction. This avoids a rippling
        // chain through w_bin itself, so every bit is a flat XOR tree.
        assign w_bin[i] = ^i_data[WIDTH-1:i];
    end

    assign o_data = (i_mode == MODE_G2B) ? w_bin : w_gray;

endmodule
`default_nettype wire

// File: rtl/gray_codec_pipe.sv
`default_nettype none
// ============================================================================
// Module      : gray_codec_pipe
// Description : A two-stage valid/ready pipeline that converts binary to
//               Gray code, or Gray code to binary. The word's mode selects
//               the direction.
//                 - S1 captures the input word and its mode.
//                 - S2 holds the converted result.
//               Conversion happens between S1 and S2.
//               Latency is 2 cycles. Throughput is one word per cycle.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - input handshake
//               in_mode, in_data    - word and its conversion mode
//               out_valid/out_ready - output handshake
//               out_mode, out_data  - converted word and the mode it used
//               out_par             - even parity of out_data
//                                     (only with GRAY_CODEC_PARITY_EN)
// Config      : GRAY_CODEC_PARITY_EN - adds the registered out_par output
// Revision    : 1.0 - initial release
// ============================================================================
module gray_codec_pipe
    import gray_codec_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
`ifdef GRAY_CODEC_PARITY_EN
    output logic [WIDTH-1:0] out_data,
    output logic             out_par
`else
    output logic [WIDTH-1:0] out_data
`endif
);

    logic             r_s1_valid;
    logic             r_s1_mode;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_s2_valid;
    logic             r_s2_mode;
    logic [WIDTH-1:0] r_s2_data;

    logic             w_s2_adv;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_conv;

    // S2 may take a new value when it is empty, or when its current word
    // leaves this cycle.
    assign w_s2_adv  = !r_s2_valid || out_ready;
    // Input is gated by rst so nothing is accepted while the pipe clears.
    assign in_ready  = !rst && (!r_s1_valid || w_s2_adv);
    assign w_in_fire = in_valid && in_ready;

    gray_codec_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_mode (r_s1_mode),
        .i_data (r_s1_data),
        .o_data (w_conv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= MODE_B2G;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_mode  <= MODE_B2G;
            r_s2_data  <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_mode  <= in_mode;
                r_s1_data  <= in_data;
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                // Payload is held when S1 is empty, so the output bus does
                // not toggle on bubbles.
                if (r_s1_valid) begin
                    r_s2_mode <= r_s1_mode;
                    r_s2_data <= w_conv;
                end
            end
        end
    end

`ifdef GRAY_CODEC_PARITY_EN
    logic r_s2_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_par <= 1'b0;
        end else if (w_s2_adv && r_s1_valid) begin
            r_s2_par <= ^w_conv;
        end
    end

    assign out_par = r_s2_par;
`endif

    assign out_valid = r_s2_valid;
    assign out_mode  = r_s2_mode;
    assign out_data  = r_s2_data;

endmodule
`default_nettype wire

// File: tb/tb_gray_codec_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_codec_pipe
// Description : Scoreboard testbench for gray_codec_pipe.
//               It runs three instances: WIDTH 4, 8 and 32. The expected
//               result of each accepted word is queued at acceptance. A
//               single monitor compares queued results against the DUT
//               outputs as they are transferred.
// Config      : GRAY_CODEC_PARITY_EN - also connects and checks out_par
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_codec_pipe;
    import gray_codec_pkg::*;

    typedef struct packed {
        logic        mode;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t q4[$];
    exp_t q8[$];
    exp_t q32[$];
    int   n8 = 0;

    // ---------------- DUT signals ----------------
    logic        d4_in_valid = 0,  d4_in_mode = 0,  d4_in_ready,  d4_out_valid,  d4_out_mode;
    logic        d4_out_ready = 1;
    logic [3:0]  d4_in_data = 0,   d4_out_data;
    logic        d8_in_valid = 0,  d8_in_mode = 0,  d8_in_ready,  d8_out_valid,  d8_out_mode;
    logic        d8_out_ready;
    logic [7:0]  d8_in_data = 0,   d8_out_data;
    logic        d32_in_valid = 0, d32_in_mode = 0, d32_in_ready, d32_out_valid, d32_out_mode;
    logic        d32_out_ready = 1;
    logic [31:0] d32_in_data = 0,  d32_out_data;
`ifdef GRAY_CODEC_PARITY_EN
    logic        d4_out_par, d8_out_par, d32_out_par;
`endif

    logic rnd8 = 0;
    logic rnd_rdy = 1;
    assign d8_out_ready = rnd8 ? rnd_rdy : 1'b1;

    always @(posedge clk) begin
        #1 rnd_rdy = ($urandom_range(0, 1) == 1);
    end

    gray_codec_pipe #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_mode(d4_in_mode), .in_data(d4_in_data),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_mode(d4_out_mode),
`ifdef GRAY_CODEC_PARITY_EN
        .out_par(d4_out_par),
`endif
        .out_data(d4_out_data)
    );

    gray_codec_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(d8_in_valid), .in_ready(d8_in_ready), .in_mode(d8_in_mode), .in_data(d8_in_data),
        .out_valid(d8_out_valid), .out_ready(d8_out_ready), .out_mode(d8_out_mode),
`ifdef GRAY_CODEC_PARITY_EN
        .out_par(d8_out_par),
`endif
        .out_data(d8_out_data)
    );

    gray_codec_pipe #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(d32_in_valid), .in_ready(d32_in_ready), .in_mode(d32_in_mode), .in_data(d32_in_data),
        .out_valid(d32_out_valid), .out_ready(d32_out_ready), .out_mode(d32_out_mode),
`ifdef GRAY_CODEC_PARITY_EN
        .out_par(d32_out_par),
`endif
        .out_data(d32_out_data)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_b2g(input logic [31:0] v);
        return v ^ (v >> 1);
    endfunction

    // Inverse Gray by doubling shifts: after the cascade every bit holds
    // the XOR of all bits above and including it.
    function automatic logic [31:0] m_g2b(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

    function automatic exp_t model(input logic m, input logic [31:0] d);
        exp_t e;
        e.mode = m;
        e.data = m ? m_g2b(d) : m_b2g(d);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        stall4 = 0, stall8 = 0;
    logic [31:0] hold4 = 0, hold8 = 0;
    logic        holdm4 = 0, holdm8 = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall4 = 0;
            stall8 = 0;
        end else begin
            if (stall4) begin
                chk("stall4_valid", {31'd0, d4_out_valid}, 32'd1);
                chk("stall4_data", {28'd0, d4_out_data}, hold4);
                chk("stall4_mode", {31'd0, d4_out_mode}, {31'd0, holdm4});
            end
            if (stall8) begin
                chk("stall8_valid", {31'd0, d8_out_valid}, 32'd1);
                chk("stall8_data", {24'd0, d8_out_data}, hold8);
                chk("stall8_mode", {31'd0, d8_out_mode}, {31'd0, holdm8});
            end

            if (d4_out_valid && d4_out_ready) begin
                if (q4.size() == 0) fail_now("w4_unexpected_output");
                else begin
                    e = q4.pop_front();
                    chk("w4_data", {28'd0, d4_out_data}, e.data);
                    chk("w4_mode", {31'd0, d4_out_mode}, {31'd0, e.mode});
`ifdef GRAY_CODEC_PARITY_EN
                    chk("w4_par", {31'd0, d4_out_par}, {31'd0, ^e.data});
`endif
                end
            end
            if (d8_out_valid && d8_out_ready) begin
                if (q8.size() == 0) fail_now("w8_unexpected_output");
                else begin
                    e = q8.pop_front();
                    n8++;
                    chk("w8_data", {24'd0, d8_out_data}, e.data);
                    chk("w8_mode", {31'd0, d8_out_mode}, {31'd0, e.mode});
`ifdef GRAY_CODEC_PARITY_EN
                    chk("w8_par", {31'd0, d8_out_par}, {31'd0, ^e.data});
`endif
                end
            end
            if (d32_out_valid && d32_out_ready) begin
                if (q32.size() == 0) fail_now("w32_unexpected_output");
                else begin
                    e = q32.pop_front();
                    chk("w32_data", d32_out_data, e.data);
                    chk("w32_mode", {31'd0, d32_out_mode}, {31'd0, e.mode});
`ifdef GRAY_CODEC_PARITY_EN
                    chk("w32_par", {31'd0, d32_out_par}, {31'd0, ^e.data});
`endif
                end
            end

            stall4 = d4_out_valid && !d4_out_ready;
            hold4  = {28'd0, d4_out_data};
            holdm4 = d4_out_mode;
            stall8 = d8_out_valid && !d8_out_ready;
            hold8  = {24'd0, d8_out_data};
            holdm8 = d8_out_mode;

            // Words that transfer in on the coming edge.
            if (d4_in_valid && d4_in_ready)   q4.push_back(model(d4_in_mode, {28'd0, d4_in_data}));
            if (d8_in_valid && d8_in_ready)   q8.push_back(model(d8_in_mode, {24'd0, d8_in_data}));
            if (d32_in_valid && d32_in_ready) q32.push_back(model(d32_in_mode, d32_in_data));
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a rising edge; it returns just after the edge on
    // which the word was accepted.
    task automatic send(input int which, input logic m, input logic [31:0] d);
        logic ok;
        ok = 1'b0;
        case (which)
            4:       begin d4_in_valid  = 1; d4_in_mode  = m; d4_in_data  = d[3:0]; end
            8:       begin d8_in_valid  = 1; d8_in_mode  = m; d8_in_data  = d[7:0]; end
            default: begin d32_in_valid = 1; d32_in_mode = m; d32_in_data = d;      end
        endcase
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = (which == 4) ? d4_in_ready : (which == 8) ? d8_in_ready : d32_in_ready;
            @(posedge clk);
            #1;
        end
        d4_in_valid  = 0;
        d8_in_valid  = 0;
        d32_in_valid = 0;
        if (!ok) fail_now("send_timeout");
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((q4.size() + q8.size() + q32.size()) != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(name, q4.size() + q8.size() + q32.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset behaviour
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in_ready_during_rst", {31'd0, d4_in_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, d4_out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, d4_in_ready}, 32'd1);
        chk("rst_out_data", {28'd0, d4_out_data}, 32'd0);
        chk("rst_out_mode", {31'd0, d4_out_mode}, 32'd0);
        chk("rst_out_valid_w32", {31'd0, d32_out_valid}, 32'd0);
`ifdef GRAY_CODEC_PARITY_EN
        chk("rst_out_par", {31'd0, d4_out_par}, 32'd0);
`endif

        // Binary to Gray with a 2-cycle latency
        @(posedge clk); #1;
        send(4, 1'b0, 32'hB);
        @(negedge clk);
        chk("lat_cycle1_valid", {31'd0, d4_out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", {31'd0, d4_out_valid}, 32'd1);
        chk("b2g_1011", {28'd0, d4_out_data}, 32'hE);
        chk("b2g_mode", {31'd0, d4_out_mode}, 32'd0);

        // Gray to binary
        @(posedge clk); #1;
        send(4, 1'b1, 32'h8);
        @(negedge clk);
        @(negedge clk);
        chk("g2b_1000", {28'd0, d4_out_data}, 32'hF);
`ifdef GRAY_CODEC_PARITY_EN
        chk("g2b_1000_par", {31'd0, d4_out_par}, 32'd0);
`endif
        drain("drain_directed");

        // Backpressure: two words fill the pipe, then the third word stalls.
        @(posedge clk); #1;
        d4_out_ready = 0;
        send(4, 1'b0, 32'h3);
        send(4, 1'b0, 32'h5);
        d4_in_valid = 1; d4_in_mode = 0; d4_in_data = 4'h6;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", {31'd0, d4_in_ready}, 32'd0);
            chk("bp_out_hold", {28'd0, d4_out_data}, 32'h2);
        end
        @(posedge clk); #1;
        d4_out_ready = 1;
        send(4, 1'b0, 32'h6);
        drain("drain_backpressure");

        // Reset with two words in flight
        @(posedge clk); #1;
        d4_out_ready = 0;
        send(4, 1'b0, 32'h1);
        send(4, 1'b1, 32'h9);
        rst = 1;
        q4.delete();
        @(posedge clk); #1;
        rst = 0;
        d4_out_ready = 1;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, d4_out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, d4_in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_no_stale", {31'd0, d4_out_valid}, 32'd0);
        end

        // WIDTH 32 extremes
        @(posedge clk); #1;
        send(32, 1'b1, 32'h8000_0000);
        @(negedge clk);
        @(negedge clk);
        chk("w32_g2b_msb", d32_out_data, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        send(32, 1'b0, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        chk("w32_b2g_ones", d32_out_data, 32'h8000_0000);
        drain("drain_w32");

        // WIDTH 8: every value, alternating modes, random out_ready
        @(posedge clk); #1;
        n8   = 0;
        rnd8 = 1;
        for (int i = 0; i < 256; i++) begin
            send(8, i[0], i);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd8 = 0;
        drain("drain_w8_stream");
        chk("w8_count", n8, 32'd256);

        // Package reference functions round-trip every 8-bit value.
        for (int v = 0; v < 256; v++) begin
            chk("pkg_roundtrip", gray2bin(bin2gray(v)), v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
